// File: rtl/cosim_pkg.sv
// Shared types and constants for the co-simulation change collector.
package cosim_pkg;

  localparam int unsigned COSIM_MAX_OP = 16;
  localparam int unsigned MAX_OP       = COSIM_MAX_OP;
  localparam int unsigned XLEN         = 64;
  localparam int unsigned ACC_W        = 8;
  localparam int unsigned OP_NUM_W     = 8;

  // csChgAccess_t encoding
  typedef enum logic [ACC_W-1:0] {
    CS_RD_XPR    = 8'h00,
    CS_WR_XPR    = 8'h01,
    CS_RD_FPR    = 8'h02,
    CS_WR_FPR    = 8'h03,
    CS_RD_CSR    = 8'h04,
    CS_WR_CSR    = 8'h05,
    CS_LD_UINT8  = 8'h10,
    CS_LD_UINT16 = 8'h11,
    CS_LD_UINT32 = 8'h12,
    CS_LD_UINT64 = 8'h13,
    CS_ST_UINT8  = 8'h20,
    CS_ST_UINT16 = 8'h21,
    CS_ST_UINT32 = 8'h22,
    CS_ST_UINT64 = 8'h23
  } cs_chg_access_t;

  typedef struct packed {
    logic [ACC_W-1:0] access;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
  } op_slot_t;

  localparam int unsigned SLOT_W = 2 * XLEN + ACC_W;
  localparam int unsigned OPS_W  = MAX_OP * SLOT_W;

  typedef struct packed {
    logic [XLEN-1:0]           pc;
    logic [XLEN-1:0]           ir;
    logic [OP_NUM_W-1:0]       op_num;
    op_slot_t [MAX_OP-1:0]     ops;
    logic                      ovf;
  } rec_t;

  localparam int unsigned REC_W = $bits(rec_t);

endpackage

// File: rtl/cosim_chg_collector_if.sv
// Event-in / record-out bus of the change collector.
interface cosim_chg_collector_if;
  import cosim_pkg::*;

  logic                in_ready;
  logic                op_valid;
  logic [XLEN-1:0]     op_addr;
  logic [XLEN-1:0]     op_data;
  logic [ACC_W-1:0]    op_access;
  logic                ret_valid;
  logic [XLEN-1:0]     ret_pc;
  logic [XLEN-1:0]     ret_ir;
  logic                rec_valid;
  logic                rec_ready;
  logic [XLEN-1:0]     rec_pc;
  logic [XLEN-1:0]     rec_ir;
  logic [OP_NUM_W-1:0] rec_op_num;
  logic [OPS_W-1:0]    rec_ops;
  logic                rec_ovf;
  logic                err_ovf;

  // Producer/consumer side (bench)
  modport master (
    input  in_ready, rec_valid, rec_pc, rec_ir, rec_op_num, rec_ops, rec_ovf, err_ovf,
    output op_valid, op_addr, op_data, op_access, ret_valid, ret_pc, ret_ir, rec_ready
  );

  // Collector side
  modport slave (
    output in_ready, rec_valid, rec_pc, rec_ir, rec_op_num, rec_ops, rec_ovf, err_ovf,
    input  op_valid, op_addr, op_data, op_access, ret_valid, ret_pc, ret_ir, rec_ready
  );
endinterface

// File: rtl/cosim_chg_fifo.sv
// Synchronous FIFO with internal count and combinational head read.
// Head output reads zero while empty.
module cosim_chg_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are qualified by count so no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cosim_chg_collector.sv
// Packs per-cycle state-change ops into one record per retired instruction
// and buffers records for the co-simulation comparator.
// Optional macro COSIM_CHG_STATS_EN adds committed-record / dropped-op counters.
module cosim_chg_collector
  import cosim_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cosim_chg_collector_if.slave bus
`ifdef COSIM_CHG_STATS_EN
  ,
  output logic [63:0]          stat_insn_cnt,
  output logic [31:0]          stat_drop_cnt
`endif
);
  localparam int unsigned CNT_W = $clog2(MAX_OP + 1);
  localparam int unsigned IDX_W = $clog2(MAX_OP);

  op_slot_t [MAX_OP-1:0] acc_q;
  op_slot_t [MAX_OP-1:0] acc_c;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_c;
  logic                  ovf_q;
  logic                  ovf_c;
  logic                  drop_c;
  logic                  err_q;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  op_take_c;
  logic                  ret_take_c;
  rec_t                  push_rec;
  rec_t                  head_rec;

  assign op_take_c  = bus.op_valid && !fifo_full;
  assign ret_take_c = bus.ret_valid && !fifo_full;

  // Fold this cycle's op into the accumulator view (also what a same-cycle retire commits)
  always_comb begin
    acc_c  = acc_q;
    cnt_c  = cnt_q;
    ovf_c  = ovf_q;
    drop_c = 1'b0;
    if (op_take_c) begin
      if (cnt_q == CNT_W'(MAX_OP)) begin
        drop_c = 1'b1;
        ovf_c  = 1'b1;
      end else begin
        acc_c[cnt_q[IDX_W-1:0]].access = bus.op_access;
        acc_c[cnt_q[IDX_W-1:0]].addr   = bus.op_addr;
        acc_c[cnt_q[IDX_W-1:0]].data   = bus.op_data;
        cnt_c = cnt_q + CNT_W'(1);
      end
    end
  end

  // Record presented to the FIFO on retire
  always_comb begin
    push_rec        = '0;
    push_rec.pc     = bus.ret_pc;
    push_rec.ir     = bus.ret_ir;
    push_rec.op_num = OP_NUM_W'(cnt_c);
    push_rec.ops    = acc_c;
    push_rec.ovf    = ovf_c;
  end

  // Accumulator state; a commit empties slots so unused slots read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= drop_c;
      if (ret_take_c) begin
        acc_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        acc_q <= acc_c;
        cnt_q <= cnt_c;
        ovf_q <= ovf_c;
      end
    end
  end

  cosim_chg_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rec_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ret_take_c),
    .din   (push_rec),
    .pop   (bus.rec_ready),
    .dout  (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.in_ready   = !fifo_full;
  assign bus.rec_valid  = !fifo_empty;
  assign bus.rec_pc     = head_rec.pc;
  assign bus.rec_ir     = head_rec.ir;
  assign bus.rec_op_num = head_rec.op_num;
  assign bus.rec_ops    = head_rec.ops;
  assign bus.rec_ovf    = head_rec.ovf;
  assign bus.err_ovf    = err_q;

`ifdef COSIM_CHG_STATS_EN
  // Saturating totals of committed records and dropped ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_insn_cnt <= '0;
      stat_drop_cnt <= '0;
    end else begin
      if (ret_take_c && (stat_insn_cnt != '1)) stat_insn_cnt <= stat_insn_cnt + 64'd1;
      if (drop_c && (stat_drop_cnt != '1))     stat_drop_cnt <= stat_drop_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cosim_chg_collector.sv
// Bench for cosim_chg_collector: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of records.
module tb_cosim_chg_collector;
  import cosim_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  ir;
    int               n;
    logic [OPS_W-1:0] ops;
    bit               ovf;
  } mrec_t;

  logic clk;
  logic rst_n;
  cosim_chg_collector_if bus ();
`ifdef COSIM_CHG_STATS_EN
  logic [63:0] stat_insn_cnt;
  logic [31:0] stat_drop_cnt;
`endif

  cosim_chg_collector #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef COSIM_CHG_STATS_EN
    ,
    .stat_insn_cnt (stat_insn_cnt),
    .stat_drop_cnt (stat_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned     vectors = 0;
  int unsigned     miscompares = 0;
  mrec_t           mq[$];
  logic [SLOT_W-1:0] cur_ops[$];
  bit              cur_ovf = 0;
  bit              exp_err = 0;
  longint unsigned m_insns = 0;
  longint unsigned m_drops = 0;
  int              err_pulses = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ops(input logic [OPS_W-1:0] exp);
    int bad;
    vectors++;
    assert (bus.rec_ops === exp) else begin
      miscompares++;
      bad = 0;
      for (int i = MAX_OP - 1; i >= 0; i--)
        if (bus.rec_ops[i*SLOT_W +: SLOT_W] !== exp[i*SLOT_W +: SLOT_W]) bad = i;
      $error("FAIL rec_ops slot %0d: observed %0h expected %0h", bad,
             bus.rec_ops[bad*SLOT_W +: SLOT_W], exp[bad*SLOT_W +: SLOT_W]);
    end
  endtask

  task automatic check_outputs();
    mrec_t h;
    h = '{pc: '0, ir: '0, n: 0, ops: '0, ovf: 1'b0};
    if (mq.size() > 0) h = mq[0];
    chk("in_ready", bus.in_ready, 128'(mq.size() < DEPTH));
    chk("rec_valid", bus.rec_valid, 128'(mq.size() > 0));
    chk("rec_pc", bus.rec_pc, h.pc);
    chk("rec_ir", bus.rec_ir, h.ir);
    chk("rec_op_num", bus.rec_op_num, 128'(h.n));
    chk("rec_ovf", bus.rec_ovf, 128'(h.ovf));
    chk_ops(h.ops);
    chk("err_ovf", bus.err_ovf, 128'(exp_err));
`ifdef COSIM_CHG_STATS_EN
    chk("stat_insn_cnt", stat_insn_cnt, 128'(m_insns));
    chk("stat_drop_cnt", stat_drop_cnt, 128'(m_drops));
`endif
  endtask

  // One clock of stimulus; model updates from pre-edge state, then outputs checked
  task automatic step(input bit ov, input logic [ACC_W-1:0] oacc, input logic [XLEN-1:0] oaddr,
                      input logic [XLEN-1:0] odata, input bit rv, input logic [XLEN-1:0] pc,
                      input logic [XLEN-1:0] ir, input bit rdy);
    bit acc;
    bit popf;
    mrec_t r;
    bus.op_valid  = ov;
    bus.op_access = oacc;
    bus.op_addr   = oaddr;
    bus.op_data   = odata;
    bus.ret_valid = rv;
    bus.ret_pc    = pc;
    bus.ret_ir    = ir;
    bus.rec_ready = rdy;
    acc  = (mq.size() < DEPTH);
    popf = rdy && (mq.size() > 0);
    @(posedge clk);
    exp_err = 0;
    if (ov && acc) begin
      if (cur_ops.size() < MAX_OP) cur_ops.push_back({oacc, oaddr, odata});
      else begin
        cur_ovf = 1;
        exp_err = 1;
        m_drops++;
      end
    end
    if (popf) void'(mq.pop_front());
    if (rv && acc) begin
      r.pc  = pc;
      r.ir  = ir;
      r.n   = cur_ops.size();
      r.ovf = cur_ovf;
      r.ops = '0;
      foreach (cur_ops[i]) r.ops[i*SLOT_W +: SLOT_W] = cur_ops[i];
      mq.push_back(r);
      cur_ops.delete();
      cur_ovf = 0;
      m_insns++;
    end
    #1;
    if (bus.err_ovf === 1'b1) err_pulses++;
    check_outputs();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, rdy);
  endtask

  task automatic retire(input logic [XLEN-1:0] pc, input bit rdy);
    step(1'b0, '0, '0, '0, 1'b1, pc, 64'h13, rdy);
  endtask

  task automatic rand_op(input bit rv, input bit rdy);
    step(1'b1, ACC_W'($urandom_range(0, 35)), {$urandom, $urandom}, {$urandom, $urandom},
         rv, {$urandom, $urandom}, {32'h0, $urandom}, rdy);
  endtask

  // Asynchronous reset taken mid-cycle; outputs must clear without a clock
  task automatic async_reset();
    bus.op_valid = 0;
    bus.ret_valid = 0;
    bus.rec_ready = 0;
    #2;
    rst_n = 0;
    mq.delete();
    cur_ops.delete();
    cur_ovf = 0;
    exp_err = 0;
    m_insns = 0;
    m_drops = 0;
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  int pulses0;
  longint unsigned drops0;

  initial begin
    rst_n = 0;
    bus.op_valid = 0; bus.op_access = '0; bus.op_addr = '0; bus.op_data = '0;
    bus.ret_valid = 0; bus.ret_pc = '0; bus.ret_ir = '0; bus.rec_ready = 0;
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1;

    // Three ops then retire
    step(1, CS_WR_XPR, 64'd5, 64'h10, 0, '0, '0, 0);
    step(1, CS_LD_UINT32, 64'h8000_0000, 64'hdead, 0, '0, '0, 0);
    step(1, CS_RD_CSR, 64'h300, 64'h8, 0, '0, '0, 0);
    retire(64'h8000_0004, 0);
    chk("t1_op_num", bus.rec_op_num, 128'd3);
    chk("t1_slot1", bus.rec_ops[SLOT_W +: SLOT_W], {CS_LD_UINT32, 64'h8000_0000, 64'hdead});
    chk("t1_hi_slots", bus.rec_ops[OPS_W-1 : 3*SLOT_W], '0);
    idle(1);

    // Same-cycle op and retire, then an empty retire
    step(1, CS_WR_CSR, 64'h341, 64'h77, 1, 64'h100, 64'h3410_1073, 0);
    chk("t2_op_num", bus.rec_op_num, 128'd1);
    retire(64'h104, 1);
    chk("t2_next_op_num", bus.rec_op_num, 128'd0);
    idle(1);

    // 18 ops: two dropped
    pulses0 = err_pulses;
    drops0  = m_drops;
    for (int i = 0; i < 18; i++) step(1, CS_ST_UINT64, 64'(i), 64'(i * 3), 0, '0, '0, 0);
    retire(64'h200, 0);
    chk("t3_op_num", bus.rec_op_num, 128'd16);
    chk("t3_ovf", bus.rec_ovf, 128'd1);
    chk("t3_pulses", 128'(err_pulses - pulses0), 128'd2);
    chk("t3_drops", 128'(m_drops - drops0), 128'd2);
    idle(1);

    // Fill the FIFO, hold a fifth retire, drain
    for (int i = 0; i < 4; i++) retire(64'h1000 + 64'(i * 4), 0);
    chk("t4_full", bus.in_ready, 128'd0);
    retire(64'h1010, 0);
    retire(64'h1010, 0);
    chk("t4_head", bus.rec_pc, 128'h1000);
    retire(64'h1010, 1);
    chk("t4_ready_back", bus.in_ready, 128'd1);
    retire(64'h1010, 1);
    for (int i = 0; i < 5; i++) idle(1);
    chk("t4_drained", bus.rec_valid, 128'd0);

    // Continuous retire with consumer always ready
    async_reset();
    for (int i = 0; i < 10; i++) retire(64'h2000 + 64'(i * 4), 1);
    idle(1);
`ifdef COSIM_CHG_STATS_EN
    chk("t5_insn", stat_insn_cnt, 128'd10);
`endif

    // Reset with buffered records and a partial record
    retire(64'h3000, 0);
    retire(64'h3004, 0);
    rand_op(0, 0);
    rand_op(0, 0);
    async_reset();
    chk("t6_valid", bus.rec_valid, 128'd0);
    retire(64'h3008, 0);
    chk("t6_op_num", bus.rec_op_num, 128'd0);
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 60) rand_op($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 50);
      else step(0, '0, '0, '0, $urandom_range(0, 99) < 25, {$urandom, $urandom}, '0,
                $urandom_range(0, 99) < 50);
    end
    for (int i = 0; i < 6; i++) idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
